// File: rtl/onehot_index_encoder_if.sv
// Mask-in / index-out stream bundle for onehot_index_encoder.
// slave = encoder side; master = mask producer plus index consumer.
interface onehot_index_encoder_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_onehot;
    logic             zero_err;

    modport slave (
        input  in_valid, in_mask, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_onehot, zero_err
    );

    modport master (
        output in_valid, in_mask, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_onehot, zero_err
    );
endinterface

// File: rtl/onehot_index_encoder.sv
// Latches a one-hot/multi-hot mask and drains the binary index of each set bit,
// one per output handshake, lowest first (or highest first with MSB_FIRST=1).
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | ready for a mask; an all-zero mask only pulses zero_err
//   S_EMIT | presenting the next index of the latched mask on the stream
module onehot_index_encoder #(
    parameter int WIDTH     = 32,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    onehot_index_encoder_if.slave        bus
);
    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic             r_onehot;
    logic             r_zero_err;

    logic [IDX_W-1:0] w_idx;
    logic [WIDTH-1:0] w_sel;
    logic             w_last;
    logic             w_accept;
    logic             w_mask_nz;
    logic             w_mask_onehot;
    logic             w_pop;

    assign w_accept      = bus.in_valid && (r_state == S_IDLE);
    assign w_mask_nz     = |bus.in_mask;
    assign w_mask_onehot = w_mask_nz && ((bus.in_mask & (bus.in_mask - WIDTH'(1))) == '0);
    assign w_pop         = bus.out_ready && (r_state == S_EMIT);
    assign w_last        = (r_pending != '0) && ((r_pending & (r_pending - WIDTH'(1))) == '0);
    assign w_sel         = WIDTH'(1) << w_idx;

    // The last matching assignment wins, so loop direction selects the priority.
    always_comb begin
        w_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++)
                if (r_pending[i]) w_idx = IDX_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (r_pending[i]) w_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_mask_nz) w_state_nxt = S_EMIT;
            S_EMIT: if (w_pop && w_last)       w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_onehot   <= 1'b0;
            r_zero_err <= 1'b0;
        end else begin
            r_zero_err <= w_accept && !w_mask_nz;
            if (w_accept && w_mask_nz) begin
                r_pending <= bus.in_mask;
                r_onehot  <= w_mask_onehot;
            end else if (w_pop) begin
                r_pending <= r_pending & ~w_sel;
            end
        end
    end

    always_comb begin
        bus.in_ready   = (r_state == S_IDLE);
        bus.out_valid  = (r_state == S_EMIT);
        bus.out_idx    = w_idx;
        bus.out_last   = w_last;
        bus.out_onehot = r_onehot && (r_state == S_EMIT);
        bus.zero_err   = r_zero_err;
    end
endmodule

// File: tb/tb_onehot_index_encoder.sv
// Directed bench: an ascending and a descending encoder driven in lockstep
// with the same masks, each checked against hand-written index sequences.
module tb_onehot_index_encoder;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    onehot_index_encoder_if #(.WIDTH(32)) ifa ();
    onehot_index_encoder_if #(.WIDTH(32)) ifb ();

    onehot_index_encoder #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .reset(reset), .bus(ifa));
    onehot_index_encoder #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct {
        logic [31:0] mask;
        int          n;
        logic [19:0] lsb_seq;
        logic [19:0] msb_seq;
        logic        onehot;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [19:0] seq4(input logic [4:0] a, input logic [4:0] b,
                                         input logic [4:0] c, input logic [4:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] mask, input logic ready);
        ifa.in_valid = valid; ifb.in_valid = valid;
        ifa.in_mask  = mask;  ifb.in_mask  = mask;
        ifa.out_ready = ready; ifb.out_ready = ready;
    endtask

    task automatic chk_beat(input string tag, input logic [4:0] ea, input logic [4:0] eb,
                            input logic last, input logic oh);
        chk({tag, " valid_a"},  32'(ifa.out_valid),  32'd1);
        chk({tag, " valid_b"},  32'(ifb.out_valid),  32'd1);
        chk({tag, " idx_a"},    32'(ifa.out_idx),    32'(ea));
        chk({tag, " idx_b"},    32'(ifb.out_idx),    32'(eb));
        chk({tag, " last_a"},   32'(ifa.out_last),   32'(last));
        chk({tag, " last_b"},   32'(ifb.out_last),   32'(last));
        chk({tag, " onehot_a"}, 32'(ifa.out_onehot), 32'(oh));
        chk({tag, " onehot_b"}, 32'(ifb.out_onehot), 32'(oh));
        chk({tag, " inrdy_a"},  32'(ifa.in_ready),   32'd0);
        chk({tag, " zerr_a"},   32'(ifa.zero_err),   32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " idle valid_a"}, 32'(ifa.out_valid), 32'd0);
        chk({tag, " idle valid_b"}, 32'(ifb.out_valid), 32'd0);
        chk({tag, " idle inrdy_a"}, 32'(ifa.in_ready),  32'd1);
        chk({tag, " idle inrdy_b"}, 32'(ifb.in_ready),  32'd1);
    endtask

    // Accept on one edge, then expect v.n beats on consecutive cycles, then IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, " pre inrdy"}, 32'(ifa.in_ready), 32'd1);
        drive(1'b1, v.mask, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, ~v.mask, 1'b1);
        for (int k = 0; k < v.n; k++) begin
            @(negedge clk);
            chk_beat($sformatf("%s b%0d", tag, k), v.lsb_seq[5*k +: 5], v.msb_seq[5*k +: 5],
                     (k == v.n - 1), v.onehot);
        end
        @(negedge clk);
        chk_idle(tag);
    endtask

    initial begin
        vec_t v;
        logic [31:0] dec;

        vecs[0] = '{32'h0000_0001, 1, seq4(0, 0, 0, 0),    seq4(0, 0, 0, 0),    1'b1};
        vecs[1] = '{32'h8000_0010, 2, seq4(4, 31, 0, 0),   seq4(31, 4, 0, 0),   1'b0};
        vecs[2] = '{32'h0000_0006, 2, seq4(1, 2, 0, 0),    seq4(2, 1, 0, 0),    1'b0};
        vecs[3] = '{32'h8000_0000, 1, seq4(31, 0, 0, 0),   seq4(31, 0, 0, 0),   1'b1};
        vecs[4] = '{32'h0000_8421, 4, seq4(0, 5, 10, 15),  seq4(15, 10, 5, 0),  1'b0};
        vecs[5] = '{32'h0001_0000, 1, seq4(16, 0, 0, 0),   seq4(16, 0, 0, 0),   1'b1};
        vecs[6] = '{32'hC000_0000, 2, seq4(30, 31, 0, 0),  seq4(31, 30, 0, 0),  1'b0};
        vecs[7] = '{32'h0000_0003, 2, seq4(0, 1, 0, 0),    seq4(1, 0, 0, 0),    1'b0};

        drive(1'b0, 32'h0, 1'b1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_idle("reset");
        chk("reset idx_a",  32'(ifa.out_idx),    32'd0);
        chk("reset last_a", 32'(ifa.out_last),   32'd0);
        chk("reset oh_a",   32'(ifa.out_onehot), 32'd0);
        chk("reset zerr_a", 32'(ifa.zero_err),   32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: index held for 3 cycles while out_ready is low.
        @(negedge clk);
        drive(1'b1, 32'h0000_0006, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'hFFFF_FFFF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_beat($sformatf("bp hold%0d", k), 5'd1, 5'd2, 1'b0, 1'b0);
        end
        ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
        @(negedge clk);
        chk_beat("bp b1", 5'd2, 5'd1, 1'b1, 1'b0);
        @(negedge clk);
        chk_idle("bp");

        // Zero mask: one-cycle zero_err, no beats.
        @(negedge clk);
        drive(1'b1, 32'h0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("zero zerr_a pulse", 32'(ifa.zero_err), 32'd1);
        chk("zero zerr_b pulse", 32'(ifb.zero_err), 32'd1);
        chk_idle("zero c1");
        @(negedge clk);
        chk("zero zerr_a drop", 32'(ifa.zero_err), 32'd0);
        chk_idle("zero c2");

        // Decoder round trip: every one-hot select maps back to its index.
        for (int s = 0; s < 32; s++) begin
            dec = 32'h1 << s;
            v = '{dec, 1, seq4(5'(s), 0, 0, 0), seq4(5'(s), 0, 0, 0), 1'b1};
            run_vec(v, $sformatf("rt%0d", s));
        end

        // in_valid held high: no accept on the final beat, re-accept after one IDLE cycle.
        @(negedge clk);
        drive(1'b1, 32'h0000_0003, 1'b1);
        @(negedge clk);
        chk_beat("hold b0", 5'd0, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        chk_beat("hold b1", 5'd1, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk_idle("hold gap");
        @(negedge clk);
        chk_beat("hold r0", 5'd0, 5'd1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk_beat("hold r1", 5'd1, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk_idle("hold end");

        // Reset mid-drain of an all-ones mask after 5 beats.
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_beat($sformatf("ones b%0d", k), 5'(k), 5'(31 - k), 1'b0, 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk_idle("midreset");
        chk("midreset idx_a",  32'(ifa.out_idx),    32'd0);
        chk("midreset idx_b",  32'(ifb.out_idx),    32'd0);
        chk("midreset last_b", 32'(ifb.out_last),   32'd0);
        chk("midreset oh_b",   32'(ifb.out_onehot), 32'd0);
        reset = 1'b0;
        v = '{32'h0000_0100, 1, seq4(8, 0, 0, 0), seq4(8, 0, 0, 0), 1'b1};
        run_vec(v, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
